// File: rtl/render_pkg.sv
// Shared types and default geometry for the fixed-function render path.
// Pure declarations: no logic, no latency.
// No flow control here; consumers own their own handshakes.
package render_pkg;

    localparam int M              = 11;
    localparam int N              = 7;
    localparam int H_RES          = 800;
    localparam int V_RES          = 600;
    localparam int FB_DEPTH       = H_RES * V_RES;
    localparam int FB_ADDR_W      = $clog2(FB_DEPTH);
    localparam int CNT_W          = 16;
    localparam int TIMEOUT_CYCLES = 2 ** 24;
    localparam int MAT_WORDS      = 16;

    typedef logic signed [M+N-1:0] fixed_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        VP    = 3'd3,
        RS    = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

    // A frame must carry a whole, non-empty list of triangles.
    function automatic logic vcount_ok(input int unsigned vc);
        return (vc != 0) && ((vc % 3) == 0);
    endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Linear address walker that streams DEPTH valid/ready writes starting at 0.
// One transfer per cycle while ready is high; done_o is combinational with the last transfer.
// valid_o is held while active; the address only advances on an accepted beat, so stalls never skip or repeat.
module fb_clear_engine #(
    parameter int DEPTH = 480000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic          done_o
);

    logic          active_q, active_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          last;

    assign last    = (addr_q == AW'(DEPTH - 1));
    assign valid_o = active_q;
    assign addr_o  = addr_q;
    assign done_o  = active_q && ready_i && last;

    // Next-state for the walker: abort beats start, start rewinds to address 0.
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        if (abort_i) begin
            active_d = 1'b0;
            addr_d   = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            addr_d   = '0;
        end else if (active_q && ready_i) begin
            if (last) begin
                active_d = 1'b0;
                addr_d   = '0;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end
    end

    // Walker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: rtl/render_sequencer.sv
// Frame controller: clear framebuffer, load 4x4 matrix, run vertex processor, then rasterizer.
// start to vp_start = 1 + H_RES*V_RES + 16 cycles with fb_clr_ready held high; DONE lasts one cycle.
// Clear stalls on fb_clr_ready; VP/RS wait on done pulses (bounded by TIMEOUT_CYCLES when RENDER_SEQ_WATCHDOG_EN is defined).
module render_sequencer #(
    parameter int M     = render_pkg::M,
    parameter int N     = render_pkg::N,
    parameter int H_RES = render_pkg::H_RES,
    parameter int V_RES = render_pkg::V_RES,
    parameter int CNT_W = render_pkg::CNT_W
`ifdef RENDER_SEQ_WATCHDOG_EN
    , parameter int TIMEOUT_CYCLES = render_pkg::TIMEOUT_CYCLES
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [7:0]                     clear_color,
    input  logic [CNT_W-1:0]               vertex_count,
    input  logic [16*(M+N)-1:0]            mat_in,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           error,
    output logic [CNT_W-1:0]               frame_cnt,
    output logic                           fb_clr_valid,
    input  logic                           fb_clr_ready,
    output logic [$clog2(H_RES*V_RES)-1:0] fb_clr_addr,
    output logic [7:0]                     fb_clr_data,
    output logic                           mat_wr_en,
    output logic [3:0]                     mat_wr_addr,
    output logic [M+N-1:0]                 mat_wr_data,
    output logic                           vp_start,
    output logic [CNT_W-1:0]               vp_count,
    input  logic                           vp_done,
    output logic                           rs_start,
    output logic [CNT_W-1:0]               rs_tri_count,
    input  logic                           rs_done,
    output logic [2:0]                     state_o
);

    import render_pkg::*;

    localparam int W     = M + N;
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = $clog2(DEPTH);

    typedef logic signed [W-1:0] word_t;

    seq_state_e       state_q;
    word_t            mat_q [16];
    logic [7:0]       color_q;
    logic [CNT_W-1:0] vcnt_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [3:0]       ld_cnt_q;
    logic             vp_start_q, rs_start_q, frame_done_q, error_q;

    logic             start_ok, clr_launch, clr_done;

`ifdef RENDER_SEQ_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_q;
    logic            wd_expired;
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    assign start_ok   = vcount_ok(32'(vertex_count));
    assign clr_launch = (state_q == IDLE) && start && !abort && start_ok;

    fb_clear_engine #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fb_clear (
        .clk     (clk),
        .rst     (rst),
        .start_i (clr_launch),
        .abort_i (abort),
        .ready_i (fb_clr_ready),
        .valid_o (fb_clr_valid),
        .addr_o  (fb_clr_addr),
        .done_o  (clr_done)
    );

    // Frame sequencing FSM with registered pulse/status outputs; abort overrides every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < 16; i++) mat_q[i] <= '0;
            color_q      <= '0;
            vcnt_q       <= '0;
            frame_cnt_q  <= '0;
            ld_cnt_q     <= '0;
            vp_start_q   <= 1'b0;
            rs_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
`ifdef RENDER_SEQ_WATCHDOG_EN
            wd_q         <= '0;
`endif
        end else begin
            vp_start_q   <= 1'b0;
            rs_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            for (int i = 0; i < 16; i++) mat_q[i] <= mat_in[i*W +: W];
                            color_q <= clear_color;
                            vcnt_q  <= vertex_count;
                            error_q <= !start_ok;
                            if (start_ok) state_q <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        ld_cnt_q <= '0;
                        if (clr_done) state_q <= LOAD;
                    end
                    LOAD: begin
                        ld_cnt_q <= ld_cnt_q + 4'd1;
                        if (ld_cnt_q == 4'd15) begin
                            state_q    <= VP;
                            vp_start_q <= 1'b1;
`ifdef RENDER_SEQ_WATCHDOG_EN
                            wd_q       <= '0;
`endif
                        end
                    end
                    VP: begin
                        if (vp_done) begin
                            state_q    <= RS;
                            rs_start_q <= 1'b1;
`ifdef RENDER_SEQ_WATCHDOG_EN
                            wd_q       <= '0;
`endif
                        end
`ifdef RENDER_SEQ_WATCHDOG_EN
                        else if (wd_expired) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
`endif
                    end
                    RS: begin
                        if (rs_done) begin
                            state_q      <= DONE;
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
                        end
`ifdef RENDER_SEQ_WATCHDOG_EN
                        else if (wd_expired) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
`endif
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign error        = error_q;
    assign frame_cnt    = frame_cnt_q;
    assign fb_clr_data  = color_q;
    assign mat_wr_en    = (state_q == LOAD);
    assign mat_wr_addr  = ld_cnt_q;
    assign mat_wr_data  = mat_wr_en ? mat_q[ld_cnt_q] : '0;
    assign vp_start     = vp_start_q;
    assign vp_count     = vcnt_q;
    assign rs_start     = rs_start_q;
    assign rs_tri_count = vcnt_q / CNT_W'(3);
    assign state_o      = state_q;

endmodule

// File: doc/render_sequencer.md
Name: render_sequencer

Overview:
- Frame-level controller for the fixed-function render path: framebuffer clear, then transform-matrix load, then vertex processor, then rasterizer.
- Takes a start pulse, a frame-coherent matrix snapshot and a vertex count.
- Issues start pulses and waits for done pulses.
- Sits between the PS-side control registers and the vertex_processor/rasterizer datapath.

Parameters:
- M, 11, integer bits of the QM.N matrix words
- N, 7, fractional bits of the QM.N matrix words
- H_RES, 800, framebuffer width in pixels
- V_RES, 600, framebuffer height in pixels
- CNT_W, 16, width of the vertex, triangle and frame counters
- TIMEOUT_CYCLES, 2**24, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begins a frame; accepted only in IDLE
- abort  in  1  returns the block to IDLE from any state next cycle
- clear_color  in  8  pixel value written during clear
- vertex_count  in  CNT_W  number of vertices in the frame
- mat_in  in  16*(M+N)  row-major 4x4 signed matrix; word 0 in LSBs
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; cleared by the next accepted start
- frame_cnt  out  CNT_W  count of completed frames; wraps
- fb_clr_valid  out  1  clear write valid
- fb_clr_ready  in  1  framebuffer accepts clear write
- fb_clr_addr  out  $clog2(H_RES*V_RES)  linear pixel address
- fb_clr_data  out  8  equals the latched clear_color
- mat_wr_en  out  1  matrix register write strobe
- mat_wr_addr  out  4  matrix word index
- mat_wr_data  out  M+N  matrix word
- vp_start  out  1  one-cycle pulse to the vertex processor
- vp_count  out  CNT_W  latched vertex_count
- vp_done  in  1  vertex processor completion pulse
- rs_start  out  1  one-cycle pulse to the rasterizer
- rs_tri_count  out  CNT_W  vertex_count/3
- rs_done  in  1  rasterizer completion pulse
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset: state = IDLE. All outputs 0, including frame_cnt and error.
- IDLE:
  - On start, latch mat_in, clear_color and vertex_count; clear error.
  - If vertex_count == 0 or vertex_count % 3 != 0: set error, stay IDLE, no frame_done.
  - Otherwise go to CLEAR with addr = 0.
- CLEAR:
  - fb_clr_valid held high; addr advances only on valid && ready.
  - When the transfer at addr = H_RES*V_RES-1 completes, go to LOAD.
  - Exactly H_RES*V_RES transfers; no address repeated or skipped under arbitrary ready stalls.
- LOAD:
  - 16 consecutive cycles of mat_wr_en; addr 0..15; data = latched word[addr].
  - Then go to VP with vp_start asserted for one cycle on entry.
- VP:
  - Wait for vp_done, then go to RS with rs_start pulsed one cycle on entry.
  - A vp_done arriving on the same cycle as vp_start is honoured.
- RS:
  - Wait for rs_done, then go to DONE.
- DONE (1 cycle):
  - frame_done = 1, frame_cnt += 1 (wraps at 2**CNT_W), then IDLE.
- busy falls in the cycle after DONE.
- start while busy is ignored; it is not queued.
- Stray vp_done or rs_done in a non-waiting state is ignored.
- abort:
  - Takes priority over all transitions; next state = IDLE.
  - Pulses squelched, no frame_done, frame_cnt unchanged, error unchanged.
- The matrix snapshot is isolated: changes on mat_in after start do not affect the current frame.
- Latency with fb_clr_ready held at 1: start to vp_start = 1 + H_RES*V_RES + 16 cycles.

Optional Feature:
- Macro: RENDER_SEQ_WATCHDOG_EN.
- Enabled:
  - A cycle counter is reset on entry to VP and on entry to RS.
  - Reaching TIMEOUT_CYCLES in either state sets error and returns to IDLE with no frame_done.
- Disabled:
  - No counter is instantiated; VP and RS wait indefinitely.

Decomposition:
- Package render_pkg:
  - M, N, H_RES, V_RES, FB_DEPTH = H_RES*V_RES, FB_ADDR_W.
  - typedef fixed_t = logic signed [M+N-1:0].
  - typedef seq_state_e {IDLE, CLEAR, LOAD, VP, RS, DONE}, 3-bit encoding.
- Sub-module fb_clear_engine: the valid/ready address walker with a done output, reusable by a future display blanker.

Test Plan:
- Nominal frame: start, vertex_count = 36, ready always 1, vp_done and rs_done returned 10 cycles after each start.
  - Expect: 480000 clear writes to addr 0..479999 with data = clear_color.
  - Expect: mat_wr words 0..15 equal to the matrix {83,-48,-83,0,34,118,-34,0,90,0,90,0,0,0,0,128}.
  - Expect: rs_tri_count = 12, frame_done once, frame_cnt = 1.
- Random fb_clr_ready (50% duty): the clear writes cover each address exactly once and in order, and vp_start asserts only after the last accepted write.
- vertex_count = 10, then vertex_count = 0: error = 1, busy never rises, no vp_start; a following valid start clears error.
- abort mid-CLEAR at addr 1000, then a new start: the clear restarts at addr 0; frame_cnt increments by 1 only after the second frame.
- start pulses while in RS, plus stray vp_done pulses: no effect, and exactly one frame_done.
- With RENDER_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES = 100, rs_done withheld: error = 1 after 100 cycles in RS, state returns to IDLE, and frame_cnt is unchanged.
